// File: rtl/multi_master_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// multi_master_bus_arbiter_if
// Bundles the CPU hold handshake, the per-master request/command lines and the
// arbitrated command strobes shared between the bus arbiter and its masters.
//
//   req      per-master bus request (bit 0 = CPU, unused by the arbiter)
//   HLDA     CPU hold acknowledge
//   RD_N     per-master read request, active low
//   WR_N     per-master write request, active low
//   IO_OR_M  per-master space select, 1 = IO, 0 = memory
//   HOLD     hold request to the CPU
//   grant    one-hot grant, all-zero during handover
//   owner    index of the granted (or last granted) master
//   IOR_N / IOW_N / MEMR_N / MEMW_N   command strobes, active low
//
// Modports:
//   master  the arbiter side that drives HOLD, grant, owner and the strobes
//   slave   the masters / CPU / decoder side that drives requests and commands
// ---------------------------------------------------------------------------
interface multi_master_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] req;
    logic                   HLDA;
    logic [NUM_MASTERS-1:0] RD_N;
    logic [NUM_MASTERS-1:0] WR_N;
    logic [NUM_MASTERS-1:0] IO_OR_M;
    logic                   HOLD;
    logic [NUM_MASTERS-1:0] grant;
    logic [OW-1:0]          owner;
    logic                   IOR_N;
    logic                   IOW_N;
    logic                   MEMR_N;
    logic                   MEMW_N;

    modport master (
        input  req, HLDA, RD_N, WR_N, IO_OR_M,
        output HOLD, grant, owner, IOR_N, IOW_N, MEMR_N, MEMW_N
    );

    modport slave (
        output req, HLDA, RD_N, WR_N, IO_OR_M,
        input  HOLD, grant, owner, IOR_N, IOW_N, MEMR_N, MEMW_N
    );
endinterface

// File: rtl/multi_master_bus_arbiter.sv
// ---------------------------------------------------------------------------
// multi_master_bus_arbiter
// Shares the system bus between the CPU (master 0, default owner) and the
// secondary masters 1..NUM_MASTERS-1 using the CPU HOLD/HLDA handshake, and
// produces the IOR_N/IOW_N/MEMR_N/MEMW_N strobes from the current owner's
// RD_N/WR_N/IO_OR_M lines.
//
// Ports:
//   clock   system clock
//   reset   synchronous reset, active low
//   bus     multi_master_bus_arbiter_if.master (requests, HLDA, commands in;
//           HOLD, grant, owner, strobes out)
//
// Parameters:
//   NUM_MASTERS      masters including the CPU (2..8)
//   PRIORITY_MODE    0 = lowest index wins, 1 = round-robin over masters 1..N-1
//   MAX_HOLD_CYCLES  clocks the bus may be kept from the CPU (0 = unlimited)
//   CMD_DELAY        extra clocks from stable command to strobe (0..7)
// ---------------------------------------------------------------------------
module multi_master_bus_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int PRIORITY_MODE   = 0,
    parameter int MAX_HOLD_CYCLES = 16,
    parameter int CMD_DELAY       = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    multi_master_bus_arbiter_if.master    bus
);
    localparam int OW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int HCW = (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
    localparam logic [NUM_MASTERS-1:0] CPU_BIT = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [3:0] DLY_DONE = 4'(CMD_DELAY + 1);

    typedef enum logic [2:0] {
        S_CPU,
        S_HOLD_REQ,
        S_TURN,
        S_GRANT,
        S_RELEASE
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_IOR,
        C_IOW,
        C_MEMR,
        C_MEMW
    } cmd_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   hold_q, hold_d;
    logic [HCW-1:0]         hcnt_q, hcnt_d;
    logic [OW-1:0]          rr_q, rr_d;
    cmd_t                   cmd_q, cmd_d;
    logic [3:0]             dcnt_q, dcnt_d;
    // Strobe vector ordered {MEMW_N, MEMR_N, IOW_N, IOR_N}
    logic [3:0]             stb_n_q, stb_n_d;

    // Winner search: MSB flags that any secondary master is pending. In
    // round-robin mode the first pending index above the last grant wins,
    // otherwise it wraps around to the lowest pending index.
    function automatic logic [OW:0] pick_winner(input logic [NUM_MASTERS-1:0] pend,
                                                input logic [OW-1:0]          last);
        logic [OW-1:0] lo;
        logic [OW-1:0] hi;
        logic          hi_ok;
        lo    = '0;
        hi    = '0;
        hi_ok = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 1; i--) begin
            if (pend[i]) begin
                lo = OW'(i);
                if (PRIORITY_MODE != 0 && OW'(i) > last) begin
                    hi    = OW'(i);
                    hi_ok = 1'b1;
                end
            end
        end
        return {|pend[NUM_MASTERS-1:1], (hi_ok ? hi : lo)};
    endfunction

    // Exactly one of RD_N/WR_N low forms a command; both or neither is idle.
    function automatic cmd_t decode_cmd(input logic rd_n, input logic wr_n, input logic io);
        cmd_t c;
        c = C_NONE;
        if (rd_n != wr_n) begin
            if (io) c = rd_n ? C_IOW : C_IOR;
            else    c = rd_n ? C_MEMW : C_MEMR;
        end
        return c;
    endfunction

    function automatic logic [3:0] strobe_low(input cmd_t c);
        logic [3:0] v;
        case (c)
            C_IOR:   v = 4'b1110;
            C_IOW:   v = 4'b1101;
            C_MEMR:  v = 4'b1011;
            C_MEMW:  v = 4'b0111;
            default: v = 4'b1111;
        endcase
        return v;
    endfunction

    logic [OW:0] win_hr;
    logic [OW:0] win_rel;
    logic        limit_hit;
    logic        strobes_idle;
    logic        on_bus;
    cmd_t        cur_cmd;

    assign win_hr       = pick_winner(bus.req & ~CPU_BIT, rr_q);
    // The outgoing owner never competes for its own handover slot.
    assign win_rel      = pick_winner(bus.req & ~CPU_BIT & ~(CPU_BIT << owner_q), rr_q);
    assign limit_hit    = (MAX_HOLD_CYCLES != 0) && (hcnt_q >= HCW'(MAX_HOLD_CYCLES));
    assign strobes_idle = &stb_n_q;
    assign on_bus       = (state_q == S_CPU) || (state_q == S_HOLD_REQ) || (state_q == S_GRANT);
    assign cur_cmd      = on_bus ? decode_cmd(bus.RD_N[owner_q], bus.WR_N[owner_q], bus.IO_OR_M[owner_q])
                                 : C_NONE;

    // Ownership FSM
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            S_CPU: begin
                owner_d = '0;
                if (|bus.req[NUM_MASTERS-1:1]) state_d = S_HOLD_REQ;
            end
            S_HOLD_REQ: begin
                if (bus.HLDA) begin
                    if (win_hr[OW]) begin
                        state_d = S_TURN;
                        owner_d = win_hr[OW-1:0];
                    end else begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_TURN: begin
                state_d = S_GRANT;
                rr_d    = owner_q;
            end
            S_GRANT: begin
                if (!bus.HLDA) begin
                    state_d = S_RELEASE;
                end else if (limit_hit && strobes_idle) begin
                    // Timeout only takes effect between bus cycles.
                    state_d = S_RELEASE;
                end else if (!bus.req[owner_q]) begin
                    if (win_rel[OW] && !limit_hit) begin
                        state_d = S_TURN;
                        owner_d = win_rel[OW-1:0];
                    end else begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (!bus.HLDA) begin
                    state_d = S_CPU;
                    owner_d = '0;
                end
            end
            default: begin
                state_d = S_CPU;
                owner_d = '0;
            end
        endcase
    end

    // Registered grant/HOLD derived from the state being entered
    always_comb begin
        grant_d = '0;
        hold_d  = 1'b0;
        case (state_d)
            S_CPU:      grant_d = CPU_BIT;
            S_HOLD_REQ: begin
                grant_d = CPU_BIT;
                hold_d  = 1'b1;
            end
            S_TURN:     hold_d = 1'b1;
            S_GRANT: begin
                grant_d = CPU_BIT << owner_d;
                hold_d  = 1'b1;
            end
            default: begin
                grant_d = '0;
                hold_d  = 1'b0;
            end
        endcase
    end

    // Hold counter: counts TURN/GRANT clocks, saturates at the limit
    always_comb begin
        hcnt_d = hcnt_q;
        if (state_d == S_CPU && state_q != S_CPU) begin
            hcnt_d = '0;
        end else if ((state_q == S_TURN || state_q == S_GRANT) && MAX_HOLD_CYCLES != 0 && !limit_hit) begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    // Strobe generation: dcnt counts clocks the same command has been seen
    // under the current owner; the strobe drops once it reaches CMD_DELAY+1.
    always_comb begin
        cmd_d   = C_NONE;
        dcnt_d  = '0;
        stb_n_d = 4'b1111;
        if (state_d != S_TURN && state_d != S_RELEASE && cur_cmd != C_NONE) begin
            cmd_d = cur_cmd;
            if (cur_cmd == cmd_q) dcnt_d = (dcnt_q == DLY_DONE) ? dcnt_q : dcnt_q + 4'd1;
            else                  dcnt_d = 4'd1;
            if (dcnt_d == DLY_DONE) stb_n_d = strobe_low(cur_cmd);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_CPU;
            owner_q <= '0;
            grant_q <= CPU_BIT;
            hold_q  <= 1'b0;
            hcnt_q  <= '0;
            rr_q    <= '0;
            cmd_q   <= C_NONE;
            dcnt_q  <= '0;
            stb_n_q <= 4'b1111;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            hcnt_q  <= hcnt_d;
            rr_q    <= rr_d;
            cmd_q   <= cmd_d;
            dcnt_q  <= dcnt_d;
            stb_n_q <= stb_n_d;
        end
    end

    assign bus.HOLD   = hold_q;
    assign bus.grant  = grant_q;
    assign bus.owner  = owner_q;
    assign bus.IOR_N  = stb_n_q[0];
    assign bus.IOW_N  = stb_n_q[1];
    assign bus.MEMR_N = stb_n_q[2];
    assign bus.MEMW_N = stb_n_q[3];

endmodule

// File: tb/tb_multi_master_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_multi_master_bus_arbiter
// Three arbiter instances (fixed priority with a 16-clock limit, round-robin
// with a 5-clock limit and zero command delay, fixed priority unlimited with a
// 3-clock command delay) share random request/command stimulus. Each instance
// has its own CPU HLDA responder and its own reference model; predicted
// outputs go into a per-instance queue and a monitor compares them every
// clock against the instance outputs.
// ---------------------------------------------------------------------------
module tb_multi_master_bus_arbiter;
    localparam int N    = 4;
    localparam int ND   = 3;
    localparam int NCYC = 6000;
    localparam int P_MODE [ND] = '{0, 1, 0};
    localparam int P_MAXH [ND] = '{16, 5, 0};
    localparam int P_DLY  [ND] = '{1, 0, 3};

    localparam int P_CPU  = 0;
    localparam int P_HREQ = 1;
    localparam int P_TURN = 2;
    localparam int P_GRNT = 3;
    localparam int P_REL  = 4;

    typedef struct {
        int         ph;
        int         own;
        int         cnt;
        int         rr;
        int         cmdq;
        int         age;
        logic [3:0] stb_n;
    } mdl_t;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [1:0]   owner;
        logic         hold;
        logic [3:0]   stb_n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_s, rd_n_s, wr_n_s, io_s;
    logic         hlda_s [ND];

    logic [N-1:0] gnt_a  [ND];
    logic [1:0]   own_a  [ND];
    logic         hold_a [ND];
    logic [3:0]   stb_a  [ND];

    mdl_t mdl [ND];
    exp_t sbq [ND][$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        multi_master_bus_arbiter_if #(.NUM_MASTERS(N)) bif ();
        assign bif.req     = req_s;
        assign bif.HLDA    = hlda_s[g];
        assign bif.RD_N    = rd_n_s;
        assign bif.WR_N    = wr_n_s;
        assign bif.IO_OR_M = io_s;
        multi_master_bus_arbiter #(
            .NUM_MASTERS    (N),
            .PRIORITY_MODE  (P_MODE[g]),
            .MAX_HOLD_CYCLES(P_MAXH[g]),
            .CMD_DELAY      (P_DLY[g])
        ) dut (
            .clock(clk),
            .reset(rst_n),
            .bus  (bif.master)
        );
        assign gnt_a[g]  = bif.grant;
        assign own_a[g]  = bif.owner;
        assign hold_a[g] = bif.HOLD;
        assign stb_a[g]  = {bif.MEMW_N, bif.MEMR_N, bif.IOW_N, bif.IOR_N};
    end

    // Next secondary master to serve, 0 if none. Round-robin scans the ring
    // 1..N-1 starting just after the last granted index.
    function automatic int pick(input logic [N-1:0] r, input int excl, input int last, input int mode);
        int idx;
        for (int k = 1; k < N; k++) begin
            idx = (mode == 0) ? k : 1 + (last - 1 + k) % (N - 1);
            if (idx != excl && r[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int mode, input int maxh, input int dly,
                                  input logic rstn, input logic [N-1:0] r, input logic hl,
                                  input logic [N-1:0] rdn, input logic [N-1:0] wrn,
                                  input logic [N-1:0] io);
        mdl_t n;
        int   cmd;
        int   w;
        bit   rd, wr, limit;
        if (!rstn) begin
            n = '{P_CPU, 0, 0, 0, 0, 0, 4'hF};
            return n;
        end
        n   = m;
        cmd = 0;
        if (m.ph == P_CPU || m.ph == P_HREQ || m.ph == P_GRNT) begin
            rd = !rdn[m.own];
            wr = !wrn[m.own];
            if (rd != wr) cmd = io[m.own] ? (rd ? 1 : 2) : (rd ? 3 : 4);
        end
        limit = (maxh != 0) && (m.cnt >= maxh);
        if ((m.ph == P_TURN || m.ph == P_GRNT) && maxh != 0 && m.cnt < maxh) n.cnt = m.cnt + 1;
        case (m.ph)
            P_CPU:  if (r[N-1:1] != 0) n.ph = P_HREQ;
            P_HREQ: if (hl) begin
                w = pick(r, 0, m.rr, mode);
                if (w != 0) begin n.ph = P_TURN; n.own = w; end
                else n.ph = P_REL;
            end
            P_TURN: begin n.ph = P_GRNT; n.rr = m.own; end
            P_GRNT: begin
                if (!hl) n.ph = P_REL;
                else if (limit && m.stb_n == 4'hF) n.ph = P_REL;
                else if (!r[m.own]) begin
                    w = pick(r, m.own, m.rr, mode);
                    if (w != 0 && !limit) begin n.ph = P_TURN; n.own = w; end
                    else n.ph = P_REL;
                end
            end
            default: if (!hl) begin n.ph = P_CPU; n.own = 0; n.cnt = 0; end
        endcase
        if (n.ph == P_TURN || n.ph == P_REL || cmd == 0) begin
            n.cmdq  = 0;
            n.age   = 0;
            n.stb_n = 4'hF;
        end else begin
            n.age   = (cmd == m.cmdq) ? ((m.age + 1 > dly + 1) ? dly + 1 : m.age + 1) : 1;
            n.cmdq  = cmd;
            n.stb_n = (n.age == dly + 1) ? ~(4'(4'b0001 << (cmd - 1))) : 4'hF;
        end
        return n;
    endfunction

    function automatic exp_t exp_of(input mdl_t m);
        exp_t e;
        if (m.ph == P_CPU || m.ph == P_HREQ) e.grant = 4'b0001;
        else if (m.ph == P_GRNT)             e.grant = 4'(1 << m.own);
        else                                 e.grant = 4'b0000;
        e.owner = 2'(m.own);
        e.hold  = (m.ph == P_HREQ || m.ph == P_TURN || m.ph == P_GRNT);
        e.stb_n = m.stb_n;
        return e;
    endfunction

    task automatic advance();
        for (int k = 0; k < ND; k++) begin
            mdl[k] = step(mdl[k], P_MODE[k], P_MAXH[k], P_DLY[k], rst_n, req_s, hlda_s[k],
                          rd_n_s, wr_n_s, io_s);
            sbq[k].push_back(exp_of(mdl[k]));
        end
    endtask

    task automatic drive_random(input int c);
        int  churn;
        bit  h;
        churn = (c < 2000) ? 8 : ((c < 4000) ? 40 : 4);
        rst_n = (c < 3) ? 1'b0 : 1'($urandom_range(0, 399) != 0);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, churn - 1) == 0) req_s[i] = ~req_s[i];
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    begin rd_n_s[i] = 1'b1; wr_n_s[i] = 1'b1; end
                    2, 5:    begin rd_n_s[i] = 1'b0; wr_n_s[i] = 1'b1; end
                    3:       begin rd_n_s[i] = 1'b1; wr_n_s[i] = 1'b0; end
                    default: begin rd_n_s[i] = 1'b0; wr_n_s[i] = 1'b0; end
                endcase
            end
            if ($urandom_range(0, 7) == 0) io_s[i] = ~io_s[i];
        end
        // CPU responder: acknowledges HOLD after a random wait, drops HLDA
        // once HOLD goes away, and very rarely withdraws it unasked.
        for (int k = 0; k < ND; k++) begin
            h = exp_of(mdl[k]).hold;
            if (h && !hlda_s[k])      hlda_s[k] = ($urandom_range(0, 2) == 0);
            else if (!h && hlda_s[k]) hlda_s[k] = ($urandom_range(0, 1) == 0);
            else if (h && hlda_s[k])  hlda_s[k] = ($urandom_range(0, 150) != 0);
        end
    endtask

    // Monitor: compare every instance output against its queued prediction
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < ND; k++) begin
                if (sbq[k].size() > 0) begin
                    e   = sbq[k].pop_front();
                    got = {gnt_a[k], own_a[k], hold_a[k], stb_a[k]};
                    n_checks++;
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL dut%0d outputs t=%0t: got grant=%b owner=%0d HOLD=%b strobes{MW,MR,IW,IR}=%b, expected grant=%b owner=%0d HOLD=%b strobes=%b",
                                 k, $time, got.grant, got.owner, got.hold, got.stb_n,
                                 e.grant, e.owner, e.hold, e.stb_n);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst_n  = 1'b0;
        req_s  = '0;
        rd_n_s = '1;
        wr_n_s = '1;
        io_s   = '0;
        for (int k = 0; k < ND; k++) begin
            hlda_s[k] = 1'b0;
            mdl[k]    = '{P_CPU, 0, 0, 0, 0, 0, 4'hF};
        end
        advance();
        for (int c = 1; c < NCYC; c++) begin
            @(negedge clk);
            drive_random(c);
            advance();
        end
        @(posedge clk);
        #4;
        for (int k = 0; k < ND; k++) begin
            n_checks++;
            if (sbq[k].size() != 0) begin
                n_fail++;
                $display("FAIL dut%0d drain: %0d predictions left unchecked, expected 0", k, sbq[k].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
